recovery_pec_checker: RTL and testbench
=======================================

# recovery_pec_checker

Parametrised streaming CRC generator/checker for the recovery interface, replacing the fixed CRC-8 PEC accumulator. It accepts a valid/ready beat stream delimited by `last_i` and folds each beat into a CRC of configurable width, polynomial, init, reflection and output XOR. It either emits the frame CRC (generate mode) or compares the trailing beat against the computed CRC (check mode), and reports a one-cycle completion pulse with sticky pass/fail status. It sits between the recovery target's byte receiver/transmitter and the recovery register logic.

## Interface
- `CrcWidth`, 8: CRC width in bits, 1..32.
- `Poly`, 8'h07: generator polynomial without the implicit top term, `CrcWidth` bits (default x^8+x^2+x+1).
- `Init`, '0: register value at reset, `clear_i`, and the start of each frame.
- `DataWidth`, 8: beat width in bits; must be ≥ `CrcWidth` when check mode is used.
- `ReflectIn`, 0: 1 means each beat is processed LSB-first; 0 means MSB-first.
- `ReflectOut`, 0: 1 means the finalised CRC is bit-reversed before `XorOut`.
- `XorOut`, '0: XOR applied to the finalised CRC.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clear_i` in 1: synchronous abort and re-initialise.
- `check_mode_i` in 1: 1 selects check mode, 0 selects generate mode; sampled on the first beat of a frame.
- `valid_i` in 1: beat valid.
- `ready_o` out 1: beat accepted when `valid_i && ready_o`.
- `dat_i` in `DataWidth`: beat data.
- `last_i` in 1: final beat of the frame.
- `crc_o` out `CrcWidth`: finalised CRC of the beats folded so far.
- `len_o` out 16: count of beats folded in the current or most recent frame, saturating.
- `done_o` out 1: one-cycle frame-complete pulse.
- `pec_ok_o` out 1: check passed; sticky.
- `pec_err_o` out 1: check failed; sticky.

## Operation
- **Internal state:** `crc_q` (`CrcWidth`), `mode_q`, `len_q`, and FSM `IDLE` / `BUSY` / `RESULT`.
- **Fold:** apply `DataWidth` serial LFSR steps, combinationally unrolled. Each step computes fb = `crc_q[CrcWidth-1]` ^ bit, then `crc = (crc<<1) ^ (fb ? Poly : 0)`. Bits are taken from `dat_i` MSB-first, or LSB-first when `ReflectIn`=1.
- **Finalise:** `crc_o` = (`ReflectOut` ? bitrev(`crc_q`) : `crc_q`) ^ `XorOut`. This path is combinational from registers only.
- **IDLE:** `ready_o`=1. On an accepted beat:
  - latch `mode_q` from `check_mode_i`;
  - clear `pec_ok_o` and `pec_err_o`;
  - handle the beat as in BUSY, starting from `crc_q`=`Init` and `len_q`=0.
- **BUSY:** `ready_o`=1. On an accepted beat:
  - If `last_i`=0: fold the beat, `len_q`+1, stay in BUSY.
  - If `last_i`=1 and `mode_q`=0: fold the beat, `len_q`+1, go to RESULT.
  - If `last_i`=1 and `mode_q`=1: do not fold and do not count. Compare `dat_i[CrcWidth-1:0]` with the current `crc_o`. Set `pec_ok_o` on equal, otherwise `pec_err_o`. Go to RESULT.
- **RESULT:** one cycle, `ready_o`=0, `done_o`=1, then go to IDLE.
  - `crc_q` and `len_q` hold until the next frame's first beat, so `crc_o` and `len_o` remain readable.
  - `pec_ok_o`/`pec_err_o` hold until the next first beat or `clear_i`.
- **`len_q`:** saturates at 16'hFFFF and never wraps.
- **`clear_i`:** takes priority over everything in any state. Next cycle: FSM=IDLE, `crc_q`=`Init`, `len_q`=0, status flags 0, `done_o`=0. A beat presented with `clear_i` is dropped.
- **Single-beat frames** (`last_i` on the IDLE beat):
  - generate mode yields the CRC of that beat;
  - check mode compares against the finalised `Init`, with `len_o`=0.
- **Elaboration error** if `CrcWidth` > 32, or `Poly`/`Init`/`XorOut` exceed `CrcWidth`.

## Timing
- **Reset** (asynchronous assert, synchronous deassert at the source): FSM=IDLE, `crc_q`=`Init`, `len_q`=0, `mode_q`=0.
  - Outputs: `ready_o`=1, `done_o`=0, `pec_ok_o`=0, `pec_err_o`=0, `len_o`=0, `crc_o`=finalise(`Init`).
- **Reset mid-frame** discards the frame with no `done_o`.
- **`crc_o` and `len_o`** update in the cycle after each accepted beat.
- **`done_o`** asserts exactly one cycle after the `last_i` beat is accepted. `crc_o`, `len_o` and status are final in that same cycle.
- **Throughput:** one beat per cycle within a frame; one dead cycle (RESULT) between frames.
- **Holding `valid_i`** high across RESULT is legal; the held beat is accepted in the following IDLE cycle.

## Test plan
- **Default params, generate mode:** "123456789" (0x31..0x39), `last_i` on 0x39 -> `done_o` the next cycle with `crc_o`=0xF4 and `len_o`=9. Single-beat frames 0x00 -> 0x00, 0x01 -> 0x07, 0xFF -> 0xF3.
- **Default params, check mode:**
  - "123456789" followed by 0xF4 with `last_i` -> `pec_ok_o`=1, `pec_err_o`=0, `len_o`=9.
  - Repeating the frame with trailer 0xF5 -> `pec_err_o`=1; the first beat of the next frame clears both flags.
- **Parameterisation:** `CrcWidth`=16, `Poly`=16'h1021, `Init`=16'hFFFF, `DataWidth`=8 over "123456789" -> 0x29B1.
- **Clear and reset mid-frame:**
  - 4 beats, then `clear_i` together with a valid beat -> beat dropped, `crc_o`=finalise(`Init`), `len_o`=0, no `done_o`.
  - Same sequence with `rst_ni` pulsed asynchronously between edges -> immediate return to all reset values.
- **Backpressure and boundaries:**
  - Hold `valid_i` continuously across two back-to-back frames -> `ready_o`=0 only in the RESULT cycle, and no beat is lost or duplicated.
  - Drive 70000 beats with no `last_i` -> `len_o` saturates at 0xFFFF.

Source files
------------

// File: rtl/recovery_pec_checker.sv
// Streaming CRC generator/checker for the recovery interface: folds valid/ready
// beats into a parametrised CRC and either emits it or checks a trailing PEC beat.
module recovery_pec_checker #(
  parameter int unsigned CrcWidth   = 8,
  parameter logic [31:0] Poly       = 32'h07,
  parameter logic [31:0] Init       = 32'h0,
  parameter int unsigned DataWidth  = 8,
  parameter bit          ReflectIn  = 1'b0,
  parameter bit          ReflectOut = 1'b0,
  parameter logic [31:0] XorOut     = 32'h0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 check_mode_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] dat_i,
  input  logic                 last_i,
  output logic [CrcWidth-1:0]  crc_o,
  output logic [15:0]          len_o,
  output logic                 done_o,
  output logic                 pec_ok_o,
  output logic                 pec_err_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StBusy   = 2'd1;
  localparam logic [1:0] StResult = 2'd2;

  if (CrcWidth < 1 || CrcWidth > 32) begin : g_bad_width
    $error("recovery_pec_checker: CrcWidth must be in 1..32");
  end

  if (CrcWidth < 32) begin : g_const_range
    if ((Poly >> CrcWidth) != 32'd0 || (Init >> CrcWidth) != 32'd0 ||
        (XorOut >> CrcWidth) != 32'd0) begin : g_bad_const
      $error("recovery_pec_checker: Poly/Init/XorOut wider than CrcWidth");
    end
  end

  localparam logic [CrcWidth-1:0] PolyW = Poly[CrcWidth-1:0];
  localparam logic [CrcWidth-1:0] InitW = Init[CrcWidth-1:0];
  localparam logic [CrcWidth-1:0] XorW  = XorOut[CrcWidth-1:0];

  logic [1:0]          r_state;
  logic [CrcWidth-1:0] r_crc;
  logic [15:0]         r_len;
  logic                r_mode;
  logic                r_ok;
  logic                r_err;

  logic                w_accept;
  logic                w_first;
  logic                w_mode;
  logic [CrcWidth-1:0] w_crc_base;
  logic [15:0]         w_len_base;
  logic [15:0]         w_len_inc;
  logic [CrcWidth-1:0] w_crc_fold;
  logic [CrcWidth-1:0] w_trailer;
  logic                w_match;

  // Serial LFSR, one step per data bit, fully unrolled into one cycle.
  function automatic logic [CrcWidth-1:0] fold(input logic [CrcWidth-1:0] c,
                                               input logic [DataWidth-1:0] d);
    logic [CrcWidth-1:0] v;
    logic                b;
    logic                fb;
    v = c;
    for (int i = 0; i < DataWidth; i++) begin
      b  = ReflectIn ? d[i] : d[DataWidth-1-i];
      fb = v[CrcWidth-1] ^ b;
      v  = (v << 1) ^ (fb ? PolyW : '0);
    end
    return v;
  endfunction

  function automatic logic [CrcWidth-1:0] finalise(input logic [CrcWidth-1:0] c);
    logic [CrcWidth-1:0] r;
    for (int i = 0; i < CrcWidth; i++) begin
      r[i] = c[CrcWidth-1-i];
    end
    return (ReflectOut ? r : c) ^ XorW;
  endfunction

  assign ready_o   = (r_state != StResult);
  assign done_o    = (r_state == StResult);
  assign crc_o     = finalise(r_crc);
  assign len_o     = r_len;
  assign pec_ok_o  = r_ok;
  assign pec_err_o = r_err;

  // The first beat of a frame works from Init/zero rather than the held result.
  assign w_accept   = valid_i && ready_o;
  assign w_first    = (r_state == StIdle);
  assign w_mode     = w_first ? check_mode_i : r_mode;
  assign w_crc_base = w_first ? InitW : r_crc;
  assign w_len_base = w_first ? 16'd0 : r_len;
  assign w_len_inc  = (w_len_base == 16'hFFFF) ? w_len_base : w_len_base + 16'd1;
  assign w_crc_fold = fold(w_crc_base, dat_i);
  assign w_match    = (w_trailer == finalise(w_crc_base));

  always_comb begin
    w_trailer = '0;
    for (int i = 0; i < CrcWidth; i++) begin
      if (i < DataWidth) w_trailer[i] = dat_i[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_crc   <= InitW;
      r_len   <= 16'd0;
      r_mode  <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
    end else if (clear_i) begin
      r_state <= StIdle;
      r_crc   <= InitW;
      r_len   <= 16'd0;
      r_mode  <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StBusy: begin
          if (w_accept) begin
            if (w_first) begin
              r_mode <= check_mode_i;
              r_ok   <= 1'b0;
              r_err  <= 1'b0;
            end
            if (last_i && w_mode) begin
              r_crc   <= w_crc_base;
              r_len   <= w_len_base;
              r_ok    <= w_match;
              r_err   <= !w_match;
              r_state <= StResult;
            end else begin
              r_crc   <= w_crc_fold;
              r_len   <= w_len_inc;
              r_state <= last_i ? StResult : StBusy;
            end
          end
        end
        StResult: r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_pec_checker.sv
// Self-checking bench for recovery_pec_checker: CRC-8 default instance plus a
// CRC-16/CCITT instance sharing the same stimulus, checked through a scoreboard queue.
module tb_recovery_pec_checker;

  typedef struct {
    logic [7:0]  crc;
    logic [15:0] len;
    logic        ok;
    logic        err;
  } expect_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        check_mode_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [7:0]  dat_i = 8'h00;
  logic        last_i = 1'b0;
  logic        ready_o;
  logic [7:0]  crc_o;
  logic [15:0] len_o;
  logic        done_o;
  logic        pec_ok_o;
  logic        pec_err_o;

  logic        ready16;
  logic [15:0] crc16;
  logic [15:0] len16;
  logic        done16;
  logic        ok16;
  logic        err16;

  int      checks = 0;
  int      failures = 0;
  expect_t sbQ[$];
  expect_t e;

  recovery_pec_checker dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .check_mode_i(check_mode_i),
    .valid_i(valid_i), .ready_o(ready_o), .dat_i(dat_i), .last_i(last_i),
    .crc_o(crc_o), .len_o(len_o), .done_o(done_o), .pec_ok_o(pec_ok_o),
    .pec_err_o(pec_err_o)
  );

  recovery_pec_checker #(
    .CrcWidth(16), .Poly(32'h1021), .Init(32'hFFFF), .DataWidth(8)
  ) dut16 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .check_mode_i(check_mode_i),
    .valid_i(valid_i), .ready_o(ready16), .dat_i(dat_i), .last_i(last_i),
    .crc_o(crc16), .len_o(len16), .done_o(done16), .pec_ok_o(ok16),
    .pec_err_o(err16)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Byte-at-a-time CRC-8 (poly 0x07, init 0) as an independent reference.
  function automatic logic [7:0] crc8Model(input string s);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < s.len(); i++) begin
      c = c ^ s[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic sendBeat(input logic [7:0] d, input logic last, input logic mode);
    valid_i = 1'b1; dat_i = d; last_i = last; check_mode_i = mode;
    @(posedge clk_i); #1;
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic sendString(input string s, input logic lastOnEnd, input logic mode);
    for (int i = 0; i < s.len(); i++) sendBeat(s[i], lastOnEnd && (i == s.len() - 1), mode);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready got=%b exp=1", ready_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%b exp=0", done_o); end
    checks++; if (pec_ok_o !== 1'b0 || pec_err_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_flags got=%b%b exp=00", pec_ok_o, pec_err_o); end
    checks++; if (len_o !== 16'd0) begin failures++; $display("[TB] FAIL rst_len got=%h exp=0000", len_o); end
    checks++; if (crc_o !== 8'h00) begin failures++; $display("[TB] FAIL rst_crc got=%h exp=00", crc_o); end
    checks++; if (crc16 !== 16'hFFFF) begin failures++; $display("[TB] FAIL rst_crc16 got=%h exp=ffff", crc16); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_generate;
    logic [7:0] singleIn[3];
    logic [7:0] singleCrc[3];
    singleIn  = '{8'h00, 8'h01, 8'hFF};
    singleCrc = '{8'h00, 8'h07, 8'hF3};
    sbQ.push_back('{8'hF4, 16'd9, 1'b0, 1'b0});
    sendString("123456789", 1'b1, 1'b0);
    checks++; if (done_o !== 1'b1) begin failures++; $display("[TB] FAIL gen_done got=%b exp=1", done_o); end
    e = sbQ.pop_front();
    checks++; if (crc_o !== e.crc) begin failures++; $display("[TB] FAIL gen_crc got=%h exp=%h", crc_o, e.crc); end
    checks++; if (len_o !== e.len) begin failures++; $display("[TB] FAIL gen_len got=%0d exp=%0d", len_o, e.len); end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL gen_ready_result got=%b exp=0", ready_o); end
    @(posedge clk_i); #1;
    checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL gen_done_pulse got=%b exp=0", done_o); end
    checks++; if (crc_o !== 8'hF4) begin failures++; $display("[TB] FAIL gen_crc_hold got=%h exp=f4", crc_o); end
    for (int i = 0; i < 3; i++) begin
      sbQ.push_back('{singleCrc[i], 16'd1, 1'b0, 1'b0});
      sendBeat(singleIn[i], 1'b1, 1'b0);
      e = sbQ.pop_front();
      checks++; if (done_o !== 1'b1) begin failures++; $display("[TB] FAIL single_done[%0d] got=%b exp=1", i, done_o); end
      checks++; if (crc_o !== e.crc) begin failures++; $display("[TB] FAIL single_crc[%0d] got=%h exp=%h", i, crc_o, e.crc); end
      checks++; if (len_o !== e.len) begin failures++; $display("[TB] FAIL single_len[%0d] got=%0d exp=%0d", i, len_o, e.len); end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_check;
    logic [7:0] trailer[2];
    trailer = '{8'hF4, 8'hF5};
    for (int t = 0; t < 2; t++) begin
      sbQ.push_back('{8'hF4, 16'd9, (t == 0), (t == 1)});
      sendString("123456789", 1'b0, 1'b1);
      sendBeat(trailer[t], 1'b1, 1'b1);
      e = sbQ.pop_front();
      checks++; if (done_o !== 1'b1) begin failures++; $display("[TB] FAIL chk_done[%0d] got=%b exp=1", t, done_o); end
      checks++; if (pec_ok_o !== e.ok || pec_err_o !== e.err) begin failures++; $display("[TB] FAIL chk_flags[%0d] got=%b%b exp=%b%b", t, pec_ok_o, pec_err_o, e.ok, e.err); end
      checks++; if (len_o !== e.len) begin failures++; $display("[TB] FAIL chk_len[%0d] got=%0d exp=%0d", t, len_o, e.len); end
      checks++; if (crc_o !== e.crc) begin failures++; $display("[TB] FAIL chk_crc[%0d] got=%h exp=%h", t, crc_o, e.crc); end
      @(posedge clk_i); #1;
    end
    checks++; if (pec_err_o !== 1'b1) begin failures++; $display("[TB] FAIL chk_err_sticky got=%b exp=1", pec_err_o); end
    sendBeat(8'h31, 1'b0, 1'b0);
    checks++; if (pec_ok_o !== 1'b0 || pec_err_o !== 1'b0) begin failures++; $display("[TB] FAIL chk_flags_cleared got=%b%b exp=00", pec_ok_o, pec_err_o); end
    sbQ.push_back('{crc8Model("12"), 16'd2, 1'b0, 1'b0});
    sendBeat(8'h32, 1'b1, 1'b0);
    e = sbQ.pop_front();
    checks++; if (crc_o !== e.crc || len_o !== e.len) begin failures++; $display("[TB] FAIL chk_next_frame got=%h/%0d exp=%h/%0d", crc_o, len_o, e.crc, e.len); end
    @(posedge clk_i); #1;
    sbQ.push_back('{8'h00, 16'd0, 1'b1, 1'b0});
    sendBeat(8'h00, 1'b1, 1'b1);
    e = sbQ.pop_front();
    checks++; if (pec_ok_o !== e.ok || pec_err_o !== e.err) begin failures++; $display("[TB] FAIL chk_single_flags got=%b%b exp=%b%b", pec_ok_o, pec_err_o, e.ok, e.err); end
    checks++; if (len_o !== e.len || crc_o !== e.crc) begin failures++; $display("[TB] FAIL chk_single_len_crc got=%0d/%h exp=%0d/%h", len_o, crc_o, e.len, e.crc); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_param;
    sbQ.push_back('{8'hF4, 16'd9, 1'b0, 1'b0});
    sendString("123456789", 1'b1, 1'b0);
    e = sbQ.pop_front();
    checks++; if (done16 !== 1'b1) begin failures++; $display("[TB] FAIL p16_done got=%b exp=1", done16); end
    checks++; if (crc16 !== 16'h29B1) begin failures++; $display("[TB] FAIL p16_crc got=%h exp=29b1", crc16); end
    checks++; if (len16 !== e.len) begin failures++; $display("[TB] FAIL p16_len got=%0d exp=%0d", len16, e.len); end
    checks++; if (crc_o !== e.crc) begin failures++; $display("[TB] FAIL p8_crc got=%h exp=%h", crc_o, e.crc); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_clear_reset;
    int doneSeen;
    sendBeat(8'h5A, 1'b1, 1'b1);
    @(posedge clk_i); #1;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    checks++; if (pec_err_o !== 1'b0) begin failures++; $display("[TB] FAIL clr_idle_err got=%b exp=0", pec_err_o); end
    sendString("1234", 1'b0, 1'b0);
    valid_i = 1'b1; dat_i = 8'h35; last_i = 1'b1; clear_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; last_i = 1'b0; clear_i = 1'b0;
    checks++; if (len_o !== 16'd0) begin failures++; $display("[TB] FAIL clr_len got=%0d exp=0", len_o); end
    checks++; if (crc_o !== 8'h00) begin failures++; $display("[TB] FAIL clr_crc got=%h exp=00", crc_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL clr_ready got=%b exp=1", ready_o); end
    doneSeen = (done_o === 1'b1) ? 1 : 0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (done_o === 1'b1) doneSeen++;
    end
    checks++; if (doneSeen !== 0) begin failures++; $display("[TB] FAIL clr_no_done got=%0d exp=0", doneSeen); end
    sbQ.push_back('{8'h07, 16'd1, 1'b0, 1'b0});
    sendBeat(8'h01, 1'b1, 1'b0);
    e = sbQ.pop_front();
    checks++; if (done_o !== 1'b1 || crc_o !== e.crc || len_o !== e.len) begin failures++; $display("[TB] FAIL clr_after got=%b/%h/%0d exp=1/%h/%0d", done_o, crc_o, len_o, e.crc, e.len); end
    @(posedge clk_i); #1;
    sendString("1234", 1'b0, 1'b0);
    checks++; if (len_o !== 16'd4 || crc_o !== crc8Model("1234")) begin failures++; $display("[TB] FAIL rstmid_pre got=%0d/%h exp=4/%h", len_o, crc_o, crc8Model("1234")); end
    #3 rst_ni = 1'b0;
    #1;
    checks++; if (len_o !== 16'd0 || crc_o !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_async got=%0d/%h exp=0/00", len_o, crc_o); end
    checks++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_hs got=%b%b exp=10", ready_o, done_o); end
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (done_o !== 1'b0 || len_o !== 16'd0) begin failures++; $display("[TB] FAIL rstmid_after got=%b/%0d exp=0/0", done_o, len_o); end
  endtask

  task automatic test_back_to_back;
    string beats;
    logic  lasts[13];
    int    k;
    int    lowCount;
    int    doneCount;
    logic  acceptNow;
    beats = "123456789ABCD";
    for (int i = 0; i < 13; i++) lasts[i] = (i == 8) || (i == 12);
    sbQ.push_back('{8'hF4, 16'd9, 1'b0, 1'b0});
    sbQ.push_back('{crc8Model("ABCD"), 16'd4, 1'b0, 1'b0});
    k = 0; lowCount = 0; doneCount = 0;
    for (int cyc = 0; cyc < 40 && (k < 13 || doneCount < 2); cyc++) begin
      if (k < 13) begin
        valid_i = 1'b1; dat_i = beats[k]; last_i = lasts[k]; check_mode_i = 1'b0;
        if (ready_o !== 1'b1) lowCount++;
        acceptNow = (ready_o === 1'b1);
      end else begin
        valid_i = 1'b0; last_i = 1'b0; acceptNow = 1'b0;
      end
      @(posedge clk_i); #1;
      if (acceptNow) k++;
      if (done_o === 1'b1) begin
        doneCount++;
        if (sbQ.size() == 0) begin
          checks++; failures++; $display("[TB] FAIL b2b_extra_done got=done exp=none");
        end else begin
          e = sbQ.pop_front();
          checks++; if (crc_o !== e.crc) begin failures++; $display("[TB] FAIL b2b_crc[%0d] got=%h exp=%h", doneCount, crc_o, e.crc); end
          checks++; if (len_o !== e.len) begin failures++; $display("[TB] FAIL b2b_len[%0d] got=%0d exp=%0d", doneCount, len_o, e.len); end
        end
      end
    end
    valid_i = 1'b0; last_i = 1'b0;
    checks++; if (doneCount !== 2) begin failures++; $display("[TB] FAIL b2b_done_count got=%0d exp=2", doneCount); end
    checks++; if (lowCount !== 1) begin failures++; $display("[TB] FAIL b2b_ready_low got=%0d exp=1", lowCount); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_saturate;
    valid_i = 1'b1; dat_i = 8'hA5; last_i = 1'b0; check_mode_i = 1'b0;
    for (int i = 0; i < 65535; i++) @(posedge clk_i);
    #1;
    checks++; if (len_o !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_reach got=%h exp=ffff", len_o); end
    for (int i = 0; i < 4465; i++) @(posedge clk_i);
    #1;
    checks++; if (len_o !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_hold got=%h exp=ffff", len_o); end
    valid_i = 1'b0;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    checks++; if (len_o !== 16'd0) begin failures++; $display("[TB] FAIL sat_clear got=%h exp=0000", len_o); end
  endtask

  initial begin
    $display("[TB] recovery_pec_checker bench start");
    test_reset();
    test_generate();
    test_check();
    test_param();
    test_clear_reset();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
